// File: rtl/ula_sequencer_pkg.sv
// Shared definitions for the ULA sequencer: FSM state encoding,
// instruction field positions, the r0 index and a field-split helper.
package ula_sequencer_pkg;

   localparam int INSTR_W     = 16;
   localparam int IMM_SEL_BIT = 15;
   localparam int OP_LSB      = 12;
   localparam int RD_LSB      = 9;
   localparam int RS1_LSB     = 6;
   localparam int RS2_LSB     = 3;
   localparam int IMM_LSB     = 0;
   localparam int REG_W       = 3;
   localparam int IMM_W       = 6;

   localparam logic [REG_W-1:0] R0 = 3'd0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_WB     = 2'd3
   } state_t;

   typedef struct packed {
      logic             imm_sel;
      logic [2:0]       op;
      logic [REG_W-1:0] rd;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [IMM_W-1:0] imm6;
   } instr_fields_t;

   // rs2 and imm6 overlap in the word; both are always extracted and the
   // imm_sel bit decides which one the datapath actually uses.
   function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] w);
      instr_fields_t f;
      f.imm_sel = w[IMM_SEL_BIT];
      f.op      = w[OP_LSB  +: 3];
      f.rd      = w[RD_LSB  +: REG_W];
      f.rs1     = w[RS1_LSB +: REG_W];
      f.rs2     = w[RS2_LSB +: REG_W];
      f.imm6    = w[IMM_LSB +: IMM_W];
      return f;
   endfunction

endpackage

// File: rtl/ula_sequencer_if.sv
// Instruction handshake plus register-file/ULA control bundle between the
// sequencer (master) and its environment (slave: source + datapath).
interface ula_sequencer_if
   import ula_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
   logic               in_valid;
   logic [INSTR_W-1:0] in_instr;
   logic               in_ready;
   logic [REG_W-1:0]   rf_ra1;
   logic [REG_W-1:0]   rf_ra2;
   logic [REG_W-1:0]   rf_wa3;
   logic               rf_we3;
   logic [DATA_W-1:0]  rf_wd3;
   logic [2:0]         ula_ctrl;
   logic               srcb_sel;
   logic [DATA_W-1:0]  imm;
   logic [DATA_W-1:0]  ula_result;
   logic               ula_z;
   logic               z_flag;
   logic               done;
   logic [CNT_W-1:0]   retired;

   modport master (
      input  in_valid, in_instr, ula_result, ula_z,
      output in_ready, rf_ra1, rf_ra2, rf_wa3, rf_we3, rf_wd3,
             ula_ctrl, srcb_sel, imm, z_flag, done, retired
   );

   modport slave (
      output in_valid, in_instr, ula_result, ula_z,
      input  in_ready, rf_ra1, rf_ra2, rf_wa3, rf_we3, rf_wd3,
             ula_ctrl, srcb_sel, imm, z_flag, done, retired
   );
endinterface

// File: rtl/ula_instr_decode.sv
// Combinational field extraction from the latched instruction word, with
// the 6-bit immediate zero-extended to the datapath width.
module ula_instr_decode
   import ula_sequencer_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [INSTR_W-1:0] instr,
   output logic               imm_sel,
   output logic [2:0]         op,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   rs1,
   output logic [REG_W-1:0]   rs2,
   output logic [DATA_W-1:0]  imm
);
   instr_fields_t fields;

   assign fields  = split_instr(instr);
   assign imm_sel = fields.imm_sel;
   assign op      = fields.op;
   assign rd      = fields.rd;
   assign rs1     = fields.rs1;
   assign rs2     = fields.rs2;

   // Zero-extension: low bits come from imm6, everything above is tied low.
   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_zext
         if (gi < IMM_W) begin : g_field
            assign imm[gi] = fields.imm6[gi];
         end else begin : g_zero
            assign imm[gi] = 1'b0;
         end
      end
   endgenerate

endmodule

// File: rtl/ula_sequencer.sv
// Four-state multicycle sequencer for the RegisterFile + Mux2 + ULA
// datapath: accept, decode, execute (latch result/Z), write back.
module ula_sequencer
   import ula_sequencer_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic            iCLK,
   input  logic            iRST_N,
   ula_sequencer_if.master bus
);
   state_t             state_reg;
   state_t             state_next;
   logic [INSTR_W-1:0] instr_reg;
   logic [DATA_W-1:0]  res_reg;
   logic               z_reg;
   logic [CNT_W-1:0]   retired_reg;

   logic               dec_imm_sel;
   logic [2:0]         dec_op;
   logic [REG_W-1:0]   dec_rd;
   logic [REG_W-1:0]   dec_rs1;
   logic [REG_W-1:0]   dec_rs2;
   logic [DATA_W-1:0]  dec_imm;

   ula_instr_decode #(.DATA_W(DATA_W)) u_decode (
      .instr   (instr_reg),
      .imm_sel (dec_imm_sel),
      .op      (dec_op),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2),
      .imm     (dec_imm)
   );

   // State register; reset aborts any in-flight instruction immediately.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake/commit strobes; strobes are pure functions of
   // state so they vanish the moment reset forces IDLE.
   always_comb begin
      state_next   = state_reg;
      bus.in_ready = 1'b0;
      bus.rf_we3   = 1'b0;
      bus.done     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            state_next = ST_WB;
         end
         ST_WB: begin
            bus.done   = 1'b1;
            bus.rf_we3 = (dec_rd != R0);
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Instruction latch: only the word presented while idle is captured.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         instr_reg <= '0;
      end else if (state_reg == ST_IDLE && bus.in_valid) begin
         instr_reg <= bus.in_instr;
      end
   end

   // Result and Z capture at the end of EXEC, while the decoded controls
   // still steer the combinational register-file read and ULA.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         res_reg <= '0;
         z_reg   <= 1'b0;
      end else if (state_reg == ST_EXEC) begin
         res_reg <= bus.ula_result;
         z_reg   <= bus.ula_z;
      end
   end

   // Retired-instruction counter; wraps silently, r0 writes still count.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         retired_reg <= '0;
      end else if (state_reg == ST_WB) begin
         retired_reg <= retired_reg + 1'b1;
      end
   end

   // Control outputs follow the latched word for the whole instruction.
   assign bus.rf_ra1   = dec_rs1;
   assign bus.rf_ra2   = dec_rs2;
   assign bus.rf_wa3   = dec_rd;
   assign bus.rf_wd3   = res_reg;
   assign bus.ula_ctrl = dec_op;
   assign bus.srcb_sel = dec_imm_sel;
   assign bus.imm      = dec_imm;
   assign bus.z_flag   = z_reg;
   assign bus.retired  = retired_reg;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer with a register-file/ULA model and an
// expected-result queue filled at accept time and drained at retire.
module tb_ula_sequencer;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ula_sequencer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   ula_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .bus    (bus)
   );

   // ULA: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not A, 6 pass B, 7 slt
   function automatic logic [7:0] ula_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return b;
         default: return {7'd0, (a < b)};
      endcase
   endfunction

   // Datapath model driven by the DUT's control outputs
   logic [7:0] rf_m [8] = '{8'h00, 8'h1E, 8'h55, 8'h1E, 8'h07, 8'hA3, 8'hF0, 8'h0F};
   logic [7:0] srcb_m;
   logic [7:0] res_m;
   always_comb begin
      srcb_m = bus.srcb_sel ? bus.imm : rf_m[bus.rf_ra2];
      res_m  = ula_f(bus.ula_ctrl, rf_m[bus.rf_ra1], srcb_m);
   end
   assign bus.ula_result = res_m;
   assign bus.ula_z      = (res_m == 8'h00);
   always @(posedge clk) begin
      if (bus.rf_we3) rf_m[bus.rf_wa3] <= bus.rf_wd3;
   end

   typedef struct {
      logic [15:0] instr;
      logic [2:0]  wa;
      logic [7:0]  wd;
      logic        we;
      logic        z;
      int          acc_cyc;
   } exp_t;

   exp_t       sb[$];
   int         acc_log[$];
   logic [7:0] sh [8] = '{8'h00, 8'h1E, 8'h55, 8'h1E, 8'h07, 8'hA3, 8'hF0, 8'h0F};
   logic [CNT_W-1:0] exp_ret = '0;
   logic       ret_pending = 1'b0;
   int         cyc = 0;
   int         passed = 0;
   int         total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   function automatic logic [36:0] snap();
      return {bus.in_ready, bus.rf_we3, bus.done, bus.z_flag, bus.retired, bus.ula_ctrl,
              bus.rf_ra1, bus.rf_ra2, bus.rf_wa3, bus.srcb_sel, bus.imm, bus.rf_wd3};
   endfunction

   // Expected outcome of an accepted word, from the bench's shadow registers
   task automatic push(input logic [15:0] w);
      exp_t       e;
      logic [7:0] a;
      logic [7:0] b;
      a = sh[w[8:6]];
      b = w[15] ? {2'b00, w[5:0]} : sh[w[5:3]];
      e.instr   = w;
      e.wa      = w[11:9];
      e.wd      = ula_f(w[14:12], a, b);
      e.we      = (w[11:9] != 3'd0);
      e.z       = (e.wd == 8'h00);
      e.acc_cyc = cyc;
      sb.push_back(e);
      acc_log.push_back(cyc);
   endtask

   // Advance one clock from a negedge to the next and check what is visible
   task automatic cycle();
      exp_t e;
      if (bus.in_ready && bus.in_valid) push(bus.in_instr);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (ret_pending) begin
         chk("retired_count", 64'(bus.retired), 64'(exp_ret));
         ret_pending = 1'b0;
      end
      chk("in_ready", 64'(bus.in_ready), 64'(sb.size() == 0));
      if (!bus.in_ready && sb.size() > 0) begin
         e = sb[0];
         chk("rf_ra1",   64'(bus.rf_ra1),   64'(e.instr[8:6]));
         chk("rf_ra2",   64'(bus.rf_ra2),   64'(e.instr[5:3]));
         chk("ula_ctrl", 64'(bus.ula_ctrl), 64'(e.instr[14:12]));
         chk("srcb_sel", 64'(bus.srcb_sel), 64'(e.instr[15]));
         chk("imm",      64'(bus.imm),      64'({2'b00, e.instr[5:0]}));
      end
      if (bus.done) begin
         if (sb.size() == 0) begin
            chk("done_without_instr", 64'(bus.done), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("wb_latency", 64'(cyc - e.acc_cyc), 64'd3);
            chk("rf_wa3",     64'(bus.rf_wa3),      64'(e.wa));
            chk("rf_wd3",     64'(bus.rf_wd3),      64'(e.wd));
            chk("rf_we3",     64'(bus.rf_we3),      64'(e.we));
            chk("z_flag",     64'(bus.z_flag),      64'(e.z));
            chk("retired_pre", 64'(bus.retired),    64'(exp_ret));
            $display("retire instr=%04h wa=%0d wd=%02h we=%0b z=%0b cyc=%0d",
                     e.instr, bus.rf_wa3, bus.rf_wd3, bus.rf_we3, bus.z_flag, cyc);
            if (e.we) sh[e.wa] = e.wd;
            exp_ret     = exp_ret + 1'b1;
            ret_pending = 1'b1;
         end
      end else begin
         chk("we_outside_wb", 64'(bus.rf_we3), 64'd0);
      end
   endtask

   task automatic run_one(input logic [15:0] w);
      int n = 0;
      while (!bus.in_ready && n < 8) begin
         cycle();
         n++;
      end
      bus.in_valid = 1'b1;
      bus.in_instr = w;
      cycle();
      bus.in_valid = 1'b0;
      bus.in_instr = 16'($urandom);
      repeat (4) cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "time limit reached");
   end

   initial begin
      logic [36:0] idle_exp;
      logic [15:0] b2b [3];
      int k;
      int guard;
      idle_exp = {1'b1, 36'd0};
      b2b[0] = 16'h2D78;
      b2b[1] = 16'h8FAA;
      b2b[2] = 16'h72B0;
      bus.in_valid = 1'b0;
      bus.in_instr = 16'h0000;

      // Reset state, then 20 idle cycles with nothing changing
      repeat (3) @(negedge clk);
      chk("reset_state", 64'(snap()), 64'(idle_exp));
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk("idle_hold", 64'(snap()), 64'(idle_exp));
      end

      // Register-register add: r2 = r1 + r3 = 3C
      run_one(16'h0458);
      // Immediate subtract to zero: r5 = r4 - 7, Z set
      run_one(16'h9B07);
      // r0 destination: no write, Z still updates (or -> 1E, Z clear)
      run_one(16'h3058);

      // Back-to-back with in_valid held high; garbage while busy
      acc_log.delete();
      k = 0;
      guard = 0;
      bus.in_valid = 1'b1;
      while (k < 3 && guard < 20) begin
         if (bus.in_ready) begin
            bus.in_instr = b2b[k];
            k++;
         end else begin
            bus.in_instr = 16'($urandom);
         end
         cycle();
         guard++;
      end
      bus.in_valid = 1'b0;
      repeat (4) cycle();
      chk("b2b_accepts", 64'(acc_log.size()), 64'd3);
      if (acc_log.size() == 3) begin
         chk("b2b_gap1", 64'(acc_log[1] - acc_log[0]), 64'd4);
         chk("b2b_gap2", 64'(acc_log[2] - acc_log[0]), 64'd8);
      end

      // Reset during EXEC: abort with no write and no retire pulse
      bus.in_valid = 1'b1;
      bus.in_instr = 16'h1250;
      cycle();
      bus.in_valid = 1'b0;
      cycle();
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
      chk("abort_we",       64'(bus.rf_we3),   64'd0);
      chk("abort_done",     64'(bus.done),     64'd0);
      chk("abort_ctrl",     64'({bus.ula_ctrl, bus.rf_ra1}), 64'd0);
      sb.delete();
      ret_pending = 1'b0;
      exp_ret = '0;
      @(negedge clk);
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (2) cycle();
      chk("abort_retired", 64'(bus.retired), 64'd0);
      $display("abort done retired=%0d", bus.retired);

      // Recovery reads r1 (would expose a partial write), then run until
      // the retired counter wraps
      run_one(16'h0458);
      for (int i = 0; i < 16; i++) run_one(16'($urandom));
      chk("retired_final", 64'(bus.retired), 64'd1);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
